// File: rtl/VX_gpu_pkg.sv
// Shared warp-scheduling types: per-warp lifecycle state and the event-resolution helper.
package VX_gpu_pkg;

  typedef enum logic [1:0] {
    WS_READY  = 2'd0,
    WS_PEND   = 2'd1,
    WS_WSTALL = 2'd2
  } warp_state_e;

  typedef struct packed {
    warp_state_e st;
    logic        err;
  } ws_upd_t;

  // Decode resolves first, unlock sees the post-decode state, then a fire moves a READY warp to PEND.
  function automatic ws_upd_t ws_apply(warp_state_e st, logic dec, logic dec_wstall,
                                       logic unl, logic fire);
    ws_upd_t r;
    r.st  = st;
    r.err = 1'b0;
    if (dec) begin
      if (r.st == WS_PEND) r.st = dec_wstall ? WS_WSTALL : WS_READY;
      else                 r.err = 1'b1;
    end
    if (unl) begin
      if (r.st == WS_WSTALL) r.st = WS_READY;
      else                   r.err = 1'b1;
    end
    if (fire) r.st = WS_PEND;
    return r;
  endfunction

endpackage

// File: rtl/vx_rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping at N-1 -> 0.
module vx_rr_picker #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);

  int c;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    c       = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr_i) + i) % N;
      if (!valid_o && req_i[c]) begin
        valid_o = 1'b1;
        idx_o   = W'(c);
      end
    end
  end

endmodule

// File: rtl/vx_warp_stall_ctrl.sv
// Scheduler-side warp lifecycle tracker: READY/PEND/WSTALL per warp, round-robin offer
// register toward fetch, per-warp deadlock watchdog and sticky protocol error.
module vx_warp_stall_ctrl
  import VX_gpu_pkg::*;
#(
  parameter int NUM_WARPS      = 4,
  parameter int WID_WIDTH      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 decode_valid_i,
  input  logic                 decode_is_wstall_i,
  input  logic [WID_WIDTH-1:0] decode_wid_i,
  input  logic                 unlock_valid_i,
  input  logic [WID_WIDTH-1:0] unlock_wid_i,
  input  logic [NUM_WARPS-1:0] active_mask_i,
  output logic                 sched_valid_o,
  output logic [WID_WIDTH-1:0] sched_wid_o,
  input  logic                 sched_ready_i,
  output logic [NUM_WARPS-1:0] stalled_mask_o,
  output logic [NUM_WARPS-1:0] wstall_mask_o,
  output logic [NUM_WARPS-1:0] timeout_mask_o,
  output logic                 protocol_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  warp_state_e state_q [NUM_WARPS];
  warp_state_e state_d [NUM_WARPS];
  ws_upd_t     upd     [NUM_WARPS];

  logic [NUM_WARPS-1:0][CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [NUM_WARPS-1:0] stalled_q, stalled_d, wstall_q, wstall_d, timeout_q, timeout_d;
  logic [NUM_WARPS-1:0] ready_vec, offer_oh, elig, upd_err;
  logic                 err_q, err_d;
  logic                 sched_valid_q, sched_valid_d;
  logic [WID_WIDTH-1:0] sched_wid_q, sched_wid_d, rr_q, rr_d;
  logic                 fire, pick_valid;
  logic [WID_WIDTH-1:0] pick_idx;

  assign fire = sched_valid_q & sched_ready_i;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign upd[w] = ws_apply(state_q[w],
                             decode_valid_i && (decode_wid_i == WID_WIDTH'(w)),
                             decode_is_wstall_i,
                             unlock_valid_i && (unlock_wid_i == WID_WIDTH'(w)),
                             fire && (sched_wid_q == WID_WIDTH'(w)));
    assign state_d[w]   = upd[w].st;
    assign upd_err[w]   = upd[w].err;
    assign ready_vec[w] = (state_q[w] == WS_READY);
    assign offer_oh[w]  = sched_valid_q && (sched_wid_q == WID_WIDTH'(w));
    assign stalled_d[w] = (upd[w].st != WS_READY);
    assign wstall_d[w]  = (upd[w].st == WS_WSTALL);
    // Counter tracks time spent non-READY so far; it is not reset by PEND->WSTALL.
    assign wd_cnt_d[w]  = ready_vec[w] ? '0 :
                          (wd_cnt_q[w] == CNT_MAX) ? wd_cnt_q[w] : wd_cnt_q[w] + CNT_W'(1);
    assign timeout_d[w] = timeout_q[w] | (wd_cnt_d[w] == CNT_MAX);
  end

  assign err_d = err_q | (|upd_err);
  assign elig  = active_mask_i & ready_vec & ~offer_oh;

  vx_rr_picker #(
    .N (NUM_WARPS),
    .W (WID_WIDTH)
  ) u_picker (
    .req_i   (elig),
    .ptr_i   (rr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // An offer is never withdrawn: only an empty register or a fire reloads it.
  always_comb begin
    sched_valid_d = sched_valid_q;
    sched_wid_d   = sched_wid_q;
    rr_d          = rr_q;
    if (!sched_valid_q || fire) begin
      sched_valid_d = pick_valid;
      sched_wid_d   = pick_idx;
    end
    if (fire) begin
      rr_d = (sched_wid_q == WID_WIDTH'(NUM_WARPS - 1)) ? '0 : sched_wid_q + WID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int w = 0; w < NUM_WARPS; w++) state_q[w] <= WS_READY;
      wd_cnt_q      <= '0;
      stalled_q     <= '0;
      wstall_q      <= '0;
      timeout_q     <= '0;
      err_q         <= 1'b0;
      sched_valid_q <= 1'b0;
      sched_wid_q   <= '0;
      rr_q          <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) state_q[w] <= state_d[w];
      wd_cnt_q      <= wd_cnt_d;
      stalled_q     <= stalled_d;
      wstall_q      <= wstall_d;
      timeout_q     <= timeout_d;
      err_q         <= err_d;
      sched_valid_q <= sched_valid_d;
      sched_wid_q   <= sched_wid_d;
      rr_q          <= rr_d;
    end
  end

  assign sched_valid_o  = sched_valid_q;
  assign sched_wid_o    = sched_wid_q;
  assign stalled_mask_o = stalled_q;
  assign wstall_mask_o  = wstall_q;
  assign timeout_mask_o = timeout_q;
  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_vx_warp_stall_ctrl.sv
// Bench for vx_warp_stall_ctrl: directed table, hand-written corner sequences and
// randomized traffic checked against a cycle-level behavioural model.
module tb_vx_warp_stall_ctrl;

  localparam int NW = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, dv, dws, uv, rdy;
  logic [1:0] dwid, uwid;
  logic [3:0] act;
  logic       sv, perr;
  logic [1:0] sw;
  logic [3:0] stl, wst, tmo;

  int checks = 0;
  int failures = 0;

  vx_warp_stall_ctrl #(.NUM_WARPS(NW), .WID_WIDTH(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .reset_i(reset),
    .decode_valid_i(dv), .decode_is_wstall_i(dws), .decode_wid_i(dwid),
    .unlock_valid_i(uv), .unlock_wid_i(uwid), .active_mask_i(act),
    .sched_valid_o(sv), .sched_wid_o(sw), .sched_ready_i(rdy),
    .stalled_mask_o(stl), .wstall_mask_o(wst), .timeout_mask_o(tmo),
    .protocol_err_o(perr)
  );

  // Behavioural model: booleans per warp, age counters, an offer slot and a pointer.
  bit m_pend[NW], m_wst[NW];
  int m_age[NW];
  bit [3:0] m_to;
  bit m_err, m_sv;
  int m_sw, m_rr;

  task automatic chk(string nm, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic model_step();
    bit elig[NW];
    bit fire, found;
    int old_sw, idx;
    if (reset) begin
      for (int w = 0; w < NW; w++) begin m_pend[w] = 0; m_wst[w] = 0; m_age[w] = 0; end
      m_to = 0; m_err = 0; m_sv = 0; m_sw = 0; m_rr = 0;
      return;
    end
    fire   = m_sv && rdy;
    old_sw = m_sw;
    for (int w = 0; w < NW; w++) begin
      elig[w] = act[w] && !m_pend[w] && !m_wst[w] && !(m_sv && m_sw == w);
      if (m_pend[w] || m_wst[w]) begin
        if (m_age[w] < TO) m_age[w]++;
      end else m_age[w] = 0;
      if (m_age[w] == TO) m_to[w] = 1;
    end
    if (!m_sv || fire) begin
      found = 0; idx = 0;
      for (int j = 0; j < NW; j++)
        if (!found && elig[(m_rr + j) % NW]) begin found = 1; idx = (m_rr + j) % NW; end
      m_sv = found; m_sw = idx;
    end
    if (fire) m_rr = (old_sw + 1) % NW;
    if (dv) begin
      if (m_pend[dwid]) begin m_pend[dwid] = 0; if (dws) m_wst[dwid] = 1; end
      else m_err = 1;
    end
    if (uv) begin
      if (m_wst[uwid]) m_wst[uwid] = 0;
      else m_err = 1;
    end
    if (fire) m_pend[old_sw] = 1;
  endtask

  task automatic model_cmp();
    bit [3:0] es, ew;
    for (int w = 0; w < NW; w++) begin es[w] = m_pend[w] | m_wst[w]; ew[w] = m_wst[w]; end
    chk("m_sched_valid", sv, m_sv);
    if (m_sv) chk("m_sched_wid", sw, m_sw);
    chk("m_stalled", stl, es);
    chk("m_wstall", wst, ew);
    chk("m_timeout", tmo, m_to);
    chk("m_perr", perr, m_err);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    model_cmp();
  endtask

  task automatic idle();
    dv = 0; dws = 0; dwid = 0; uv = 0; uwid = 0;
  endtask

  typedef struct {
    logic dv, dws; logic [1:0] dwid; logic uv; logic [1:0] uwid;
    logic [3:0] act; logic rdy;
    logic esv; logic [1:0] ewid; logic [3:0] estl, ewst;
  } vec_t;
  vec_t tbl[10];

  initial begin
    // dv dws dwid uv uwid act rdy | sv wid stalled wstall
    tbl[0] = '{0, 0, 2'd0, 0, 2'd0, 4'hF, 1, 1, 2'd0, 4'h0, 4'h0};
    tbl[1] = '{0, 0, 2'd0, 0, 2'd0, 4'hF, 1, 1, 2'd1, 4'h1, 4'h0};
    tbl[2] = '{0, 0, 2'd0, 0, 2'd0, 4'hF, 1, 1, 2'd2, 4'h3, 4'h0};
    tbl[3] = '{0, 0, 2'd0, 0, 2'd0, 4'hF, 1, 1, 2'd3, 4'h7, 4'h0};
    tbl[4] = '{0, 0, 2'd0, 0, 2'd0, 4'hF, 1, 0, 2'd0, 4'hF, 4'h0};
    tbl[5] = '{0, 0, 2'd0, 0, 2'd0, 4'hF, 1, 0, 2'd0, 4'hF, 4'h0};
    tbl[6] = '{1, 0, 2'd1, 0, 2'd0, 4'hF, 1, 0, 2'd0, 4'hD, 4'h0};
    tbl[7] = '{0, 0, 2'd0, 0, 2'd0, 4'hF, 1, 1, 2'd1, 4'hD, 4'h0};
    tbl[8] = '{0, 0, 2'd0, 0, 2'd0, 4'hF, 1, 0, 2'd0, 4'hF, 4'h0};
    tbl[9] = '{1, 1, 2'd2, 0, 2'd0, 4'hF, 1, 0, 2'd0, 4'hF, 4'h4};

    reset = 1; idle(); act = 4'hF; rdy = 1;
    cyc(); cyc();
    chk("rst_sv", sv, 0); chk("rst_wid", sw, 0); chk("rst_stl", stl, 0);
    chk("rst_wst", wst, 0); chk("rst_tmo", tmo, 0); chk("rst_perr", perr, 0);
    reset = 0;

    // Tests 1-3 start: drain all warps, re-offer after plain decode, wstall decode
    for (int i = 0; i < 10; i++) begin
      dv = tbl[i].dv; dws = tbl[i].dws; dwid = tbl[i].dwid;
      uv = tbl[i].uv; uwid = tbl[i].uwid; act = tbl[i].act; rdy = tbl[i].rdy;
      cyc();
      chk($sformatf("tbl%0d_sv", i), sv, tbl[i].esv);
      if (tbl[i].esv) chk($sformatf("tbl%0d_wid", i), sw, tbl[i].ewid);
      chk($sformatf("tbl%0d_stl", i), stl, tbl[i].estl);
      chk($sformatf("tbl%0d_wst", i), wst, tbl[i].ewst);
      chk($sformatf("tbl%0d_perr", i), perr, 0);
    end

    // Test 3: wid2 held in WSTALL for 10 cycles, then unlocked and re-offered
    idle();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("wstall_not_offered", int'(sv && sw == 2'd2), 0);
    end
    uv = 1; uwid = 2; rdy = 0;
    cyc();
    chk("unlock2_wst", wst, 0); chk("unlock2_stl2", stl[2], 0);
    idle();
    cyc();
    chk("reoffer2_sv", sv, 1); chk("reoffer2_wid", sw, 2);

    // Test 4: offer held while not ready even after its active bit drops
    dv = 1; dwid = 0; dws = 0;
    cyc();
    idle(); rdy = 1;
    cyc();
    chk("offer0_sv", sv, 1); chk("offer0_wid", sw, 0);
    rdy = 0; act = 4'hE;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_sv", sv, 1); chk("hold_wid", sw, 0);
    end

    // Test 5: same-cycle decode+unlock on wid3, then an illegal unlock
    act = 4'hF; dv = 1; dws = 1; dwid = 3; uv = 1; uwid = 3;
    cyc();
    chk("same_cyc_stl3", stl[3], 0); chk("same_cyc_perr", perr, 0);
    idle(); uv = 1; uwid = 0;
    cyc();
    chk("bad_unlock_perr", perr, 1); chk("bad_unlock_stl0", stl[0], 0);
    chk("bad_unlock_wid", sw, 0);
    idle(); reset = 1;
    cyc();
    chk("rst2_perr", perr, 0); chk("rst2_sv", sv, 0); chk("rst2_tmo", tmo, 0);
    reset = 0;

    // Test 6: watchdog on a WSTALL warp, stickiness, reset mid-stall
    act = 4'b0010; rdy = 1;
    cyc(); cyc();
    act = 4'b0000; dv = 1; dws = 1; dwid = 1;
    cyc();
    chk("t6_wst", wst, 4'b0010);
    idle();
    for (int c = 4; c <= 17; c++) cyc();
    chk("t6_tmo_before", tmo, 0);
    cyc();
    chk("t6_tmo_at", tmo, 4'b0010);
    uv = 1; uwid = 1;
    cyc();
    chk("t6_tmo_sticky", tmo, 4'b0010); chk("t6_wst_clear", wst, 0);
    idle(); act = 4'b0011; rdy = 1;
    cyc(); cyc();
    rdy = 0;
    cyc();
    chk("t6_held_sv", sv, 1); chk("t6_held_wid", sw, 1); chk("t6_stl", stl, 4'b0001);
    reset = 1;
    cyc();
    chk("t6_rst_sv", sv, 0); chk("t6_rst_wid", sw, 0); chk("t6_rst_stl", stl, 0);
    chk("t6_rst_wst", wst, 0); chk("t6_rst_tmo", tmo, 0); chk("t6_rst_perr", perr, 0);
    reset = 0;

    // Randomized traffic, mostly legal events aimed at warps in the matching state
    for (int n = 0; n < 3000; n++) begin
      int cand[$];
      idle();
      reset = ($urandom_range(0, 399) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      act   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 9) < 4) begin
        dv = 1; dws = 1'($urandom); dwid = 2'($urandom);
        cand.delete();
        for (int w = 0; w < NW; w++) if (m_pend[w]) cand.push_back(w);
        if (cand.size() > 0 && $urandom_range(0, 9) < 9)
          dwid = 2'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      if ($urandom_range(0, 9) < 3) begin
        uv = 1; uwid = 2'($urandom);
        cand.delete();
        for (int w = 0; w < NW; w++) if (m_wst[w]) cand.push_back(w);
        if (cand.size() > 0 && $urandom_range(0, 9) < 9)
          uwid = 2'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
